d_ff_enable: RTL and testbench
==============================

# d_ff_enable

Load-enabled storage element for the CPU datapath: register bits, pipeline registers and register-file rows. Each bit is a `mux2_1` feeding a `D_FF`. The mux either recirculates the current `q` or selects new data `d`, so `en` gates loading without gating the clock. The block is a `WIDTH`-wide bank of identical bit cells, all sharing one clock, one reset and one enable.

## Interface
- `WIDTH`, default 1: number of bits stored; legal range 1..64.
- `clk` input, 1 bit: the single clock; all state changes on its rising edge.
- `reset` input, 1 bit: reset is synchronous and active-high. While it is high, `q` clears to 0 at the next rising edge of `clk`.
- `en` input, 1 bit: load enable. 1 = capture `d`; 0 = hold `q`.
- `d` input, `WIDTH` bits: data to load.
- `q` output, `WIDTH` bits: registered value, driven directly by the flip-flops.
- Port order follows the codebase: (`q`, `d`, `clk`, `en`, `reset`).

## Operation
- Per bit i, mux select = `en`, mux in0 = `q[i]`, mux in1 = `d[i]`, mux output = `w[i]`.
- `D_FF` captures `w[i]`.
- Next-state priority, evaluated at each rising edge of `clk`:
  - `reset`=1 gives `q`=0, regardless of `en` or `d`.
  - `reset`=0 and `en`=1 gives `q`=`d`.
  - `reset`=0 and `en`=0 gives `q` unchanged.
- Reset value of `q` is all zeros.
- Before the first reset edge or enabled load, `q` is X. Benches must assert `reset` or `en` before checking `q`.
- No combinational path from `d` or `en` to `q`.
- The mux output `w` changes combinationally with `en`/`d`/`q`, but only the edge sample matters.
- All bits are identical and independent. `en` is shared; there are no per-bit enables.

## Timing
- Latency: 1 cycle. A value present on `d` with `en`=1 at edge N appears on `q` just after edge N and is stable through edge N+1.
- Hold is indefinite while `en`=0 and `reset`=0. Toggling `d` with `en`=0 never disturbs `q`.
- `en` or `d` changing between edges has no effect; only the value at the rising edge counts.
- `reset` and `en` both high at the same edge: reset wins, `q`=0.
- `reset` asserted mid-operation clears `q` at the next edge only, never asynchronously. Loading resumes at the first edge with `reset`=0 and `en`=1.
- Timescale is `10ps/1fs`, matching the rest of the CPU.
- `d`, `en` and `reset` must meet setup/hold relative to the rising edge of `clk`.

## Structure
- Leaf module `mux2_1`:
  - Ports (`i0`, `i1`, `sel`, `out`).
  - `out` = `sel` ? `i1` : `i0`.
  - Implemented structurally from primitive gates (not, and ×2, or).
- Leaf module `D_FF`:
  - Ports (`q`, `d`, `reset`, `clk`).
  - Rising-edge capture with synchronous active-high clear.
- Natural sub-module: `d_ff_enable_bit`, a single-bit cell of one `mux2_1` plus one `D_FF`.
- Top level instantiates `WIDTH` copies of `d_ff_enable_bit` in a generate loop.
- No shared package is needed. If a `cpu_pkg` exists, the default `WIDTH` for datapath use (e.g., 64) may be referenced from it as a constant; the block itself defines no typedefs.

## Test plan
- Reset: `reset`=1, `en`=0, `d`=1 for one edge → `q`=0. Then `reset`=1, `en`=1, `d`=1 → `q` still 0 (reset priority).
- Enabled load, clock period 10, `WIDTH`=1: from `q`=0, set `d`=1, `en`=1 → `q`=1 after the next edge. Then `d`=0 → `q`=0 after the following edge.
- Hold: with `q`=0, set `en`=0, then `d`=1 for 2+ edges → `q` stays 0. Then `en`=1 → `q`=1 at the next edge. Then `d`=0 → `q`=0.
- Mid-cycle glitch: with `en`=1, pulse `d` high strictly between edges → `q` unchanged.
- Wide bank, `WIDTH`=64:
  - Load `d`=0xDEADBEEF_01234567 with `en`=1 → `q` matches.
  - `en`=0, `d`=0xFFFFFFFF_FFFFFFFF → `q` holds the first value.
  - `reset`=1 → `q`=0.
- Reset mid-operation: `q`=0xA5 (`WIDTH`=8), assert `reset` for one edge with `en`=1, `d`=0x3C → `q`=0x00. Deassert `reset` → `q`=0x3C at the next edge.

Source files
------------

// File: rtl/d_ff_enable_pkg.sv
// Shared constants for the load-enabled register bank.
// Lets datapath users name the standard widths instead of repeating literals.
`timescale 10ps/1fs

package d_ff_enable_pkg;

  localparam int DEFAULT_WIDTH  = 1;
  localparam int MIN_WIDTH      = 1;
  localparam int MAX_WIDTH      = 64;
  localparam int DATAPATH_WIDTH = 64;

  // True when a requested bank width is one the datapath supports.
  function automatic bit width_is_legal(input int width);
    return (width >= MIN_WIDTH) && (width <= MAX_WIDTH);
  endfunction

endpackage

// File: rtl/D_FF.sv
// Rising-edge flip-flop with synchronous active-high clear.
`timescale 10ps/1fs

module D_FF (
  output logic q,
  input  logic d,
  input  logic reset,
  input  logic clk
);

  always_ff @(posedge clk) begin
    if (reset)
      q <= 1'b0;
    else
      q <= d;
  end

endmodule

// File: rtl/d_ff_enable_bit.sv
// One storage bit: the mux recirculates q unless en selects new data.
// The clock is never gated, so every bit sees the same free-running edge.
`timescale 10ps/1fs

module d_ff_enable_bit (
  output logic q,
  input  logic d,
  input  logic clk,
  input  logic en,
  input  logic reset
);

  wire w;

  mux2_1 u_mux (
    .i0  (q),
    .i1  (d),
    .sel (en),
    .out (w)
  );

  D_FF u_ff (
    .q     (q),
    .d     (w),
    .reset (reset),
    .clk   (clk)
  );

endmodule

// File: rtl/mux2_1.sv
// Two-input multiplexer built from primitive gates.
// Drives i1 when sel is high and i0 when sel is low.
`timescale 10ps/1fs

module mux2_1 (
  input  logic i0,
  input  logic i1,
  input  logic sel,
  output wire  out
);

  wire sel_n;
  wire pick0;
  wire pick1;

  not u_not  (sel_n, sel);
  and u_and0 (pick0, i0, sel_n);
  and u_and1 (pick1, i1, sel);
  or  u_or   (out, pick0, pick1);

endmodule

// File: rtl/d_ff_enable.sv
// WIDTH-wide load-enabled register: identical bit cells sharing clk, reset and en.
`timescale 10ps/1fs

module d_ff_enable
  import d_ff_enable_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  output logic [WIDTH-1:0] q,
  input  logic [WIDTH-1:0] d,
  input  logic             clk,
  input  logic             en,
  input  logic             reset
);

  // Bits are fully independent; only en and reset are common to the bank.
  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    d_ff_enable_bit u_bit (
      .q     (q[i]),
      .d     (d[i]),
      .clk   (clk),
      .en    (en),
      .reset (reset)
    );
  end

endmodule

// File: tb/tb_d_ff_enable.sv
// Self-checking bench: directed cases then random traffic against a reference register.
`timescale 10ps/1fs

module tb_d_ff_enable;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        en = 1'b0;
  logic [63:0] d = '0;
  logic [63:0] q_wide;
  logic [0:0]  q_bit;

  logic [63:0] ref_q = '0;
  bit          ref_valid = 1'b0;
  int          checks = 0;
  int          failures = 0;

  always #5 clk = ~clk;

  d_ff_enable #(.WIDTH(64)) dut_wide (
    .q     (q_wide),
    .d     (d),
    .clk   (clk),
    .en    (en),
    .reset (reset)
  );

  d_ff_enable #(.WIDTH(1)) dut_bit (
    .q     (q_bit),
    .d     (d[0:0]),
    .clk   (clk),
    .en    (en),
    .reset (reset)
  );

  task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic checkBoth(input string tag);
    checkOutput(tag, q_wide, ref_q);
    checkOutput({tag, "_w1"}, {63'b0, q_bit}, {63'b0, ref_q[0]});
  endtask

  // Drive on the falling edge, confirm q has not moved early, then check after the rising edge.
  task automatic applyStimulus(input logic r, input logic e, input logic [63:0] dv, input string tag);
    @(negedge clk);
    reset = r;
    en    = e;
    d     = dv;
    #1;
    if (ref_valid) checkBoth({tag, "_pre"});
    @(posedge clk);
    if (r)      ref_q = '0;
    else if (e) ref_q = dv;
    if (r || e) ref_valid = 1'b1;
    #1;
    if (ref_valid) checkBoth(tag);
  endtask

  initial begin
    // Reset, and reset priority over a simultaneous load
    applyStimulus(1'b1, 1'b0, 64'h1, "rst");
    checkOutput("rst_zero", q_wide, 64'h0);
    applyStimulus(1'b1, 1'b1, 64'h1, "rst_pri");
    checkOutput("rst_pri_zero", q_wide, 64'h0);

    applyStimulus(1'b0, 1'b1, 64'h1, "load1");
    applyStimulus(1'b0, 1'b1, 64'h0, "load0");

    applyStimulus(1'b0, 1'b0, 64'h1, "hold_a");
    applyStimulus(1'b0, 1'b0, 64'h1, "hold_b");
    applyStimulus(1'b0, 1'b0, 64'h1, "hold_c");
    checkOutput("hold_zero", q_wide, 64'h0);
    applyStimulus(1'b0, 1'b1, 64'h1, "resume");
    checkOutput("resume_one", {63'b0, q_bit}, 64'h1);
    applyStimulus(1'b0, 1'b1, 64'h0, "clear");

    // A pulse on d strictly between edges must never be captured
    @(negedge clk);
    reset = 1'b0;
    en    = 1'b1;
    d     = '0;
    @(posedge clk);
    ref_q = '0;
    #2 d = '1;
    #3 checkOutput("glitch_mid", q_wide, 64'h0);
    #1 d = '0;
    @(posedge clk);
    #1 checkBoth("glitch_after");

    applyStimulus(1'b0, 1'b1, 64'hDEADBEEF_01234567, "wide_load");
    checkOutput("wide_load_const", q_wide, 64'hDEADBEEF_01234567);
    applyStimulus(1'b0, 1'b0, 64'hFFFFFFFF_FFFFFFFF, "wide_hold");
    checkOutput("wide_hold_const", q_wide, 64'hDEADBEEF_01234567);
    applyStimulus(1'b1, 1'b0, 64'hFFFFFFFF_FFFFFFFF, "wide_rst");

    applyStimulus(1'b0, 1'b1, 64'hA5, "mid_a5");
    applyStimulus(1'b1, 1'b1, 64'h3C, "mid_rst");
    checkOutput("mid_rst_const", q_wide, 64'h0);
    applyStimulus(1'b0, 1'b1, 64'h3C, "mid_resume");
    checkOutput("mid_resume_const", q_wide, 64'h3C);

    // Random traffic: occasional reset, enable about half the time
    for (int i = 0; i < 300; i++) begin
      applyStimulus(($urandom_range(0, 7) == 0), $urandom_range(0, 1) == 1,
                    {$urandom, $urandom}, "rand");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
    $finish;
  end

endmodule
